// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Prioritising interrupt controller in front of the CPU's IRQ/IC inputs.
// Rising edges on the request lines are latched into a pending register, a
// programmable mask hides sources, and the lowest-index unmasked pending
// source is presented to the CPU. Each interrupt walks through the request
// (ASSERT), acknowledge and end-of-interrupt (SERVICE) phases; only one
// interrupt is ever in flight or in service.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst      asynchronous active-high reset
//   req      device request lines, a rising edge raises that request
//   ack      CPU acknowledge pulse, honoured only while presenting
//   eoi      CPU end-of-interrupt pulse, honoured only while in service
//   mask_w   mask write strobe
//   mask_d   new mask value (1 = source disabled)
//   irq      interrupt request to the CPU
//   ic       index of the presented or in-service source
//   pending  latched pending requests
//   mask     current mask register
//   busy     high while presenting or servicing an interrupt
// ---------------------------------------------------------------------------
module interrupt_controller #(
   parameter logic [15:0] RESET_MASK = 16'hFFFF,
   parameter int          NUM_SRC    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] req,
   input  logic               ack,
   input  logic               eoi,
   input  logic               mask_w,
   input  logic [NUM_SRC-1:0] mask_d,
   output logic               irq,
   output logic [3:0]         ic,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] mask,
   output logic               busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [3:0]         next_ic;
   logic               next_irq;
   logic               next_busy;
   logic [NUM_SRC-1:0] prev_req;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clr;
   logic [3:0]         sel_idx;

   assign rise     = req & ~prev_req;
   assign eligible = pending & ~mask;

   // Fixed priority: scan from the top down so the lowest set index is the
   // last one written and therefore wins.
   always_comb begin
      sel_idx = 4'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            sel_idx = 4'(i);
         end
      end
   end

   // Next-state logic. IC is captured only when leaving IDLE, so it stays
   // frozen through ASSERT and SERVICE regardless of new requests or mask
   // changes. An accepted ACK produces the one-hot clear for the pending
   // register; EOI is ignored in ASSERT, so ACK+EOI together only acts as ACK.
   always_comb begin
      next_state = state;
      next_ic    = ic;
      clr        = '0;
      unique case (state)
         ST_IDLE: begin
            if (|eligible) begin
               next_state = ST_ASSERT;
               next_ic    = sel_idx;
            end
         end
         ST_ASSERT: begin
            if (ack) begin
               next_state = ST_SERVICE;
               clr        = {{(NUM_SRC-1){1'b0}}, 1'b1} << ic;
            end
         end
         ST_SERVICE: begin
            if (eoi) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
      next_irq  = (next_state == ST_ASSERT);
      next_busy = (next_state != ST_IDLE);
   end

   // State and output registers. IRQ and BUSY are registered copies of the
   // next-state decode so the CPU never sees a combinational glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         ic    <= 4'd0;
         irq   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         ic    <= next_ic;
         irq   <= next_irq;
         busy  <= next_busy;
      end
   end

   // Edge history, pending bits and mask. A rise in the same cycle as the
   // clear of that bit keeps the bit set, so no edge is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_req <= '0;
         pending  <= '0;
         mask     <= RESET_MASK;
      end else begin
         prev_req <= req;
         pending  <= (pending & ~clr) | rise;
         if (mask_w) begin
            mask <= mask_d;
         end
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//
// Self-checking bench for interrupt_controller. A behavioural model tracks
// the pending set, mask and the "presenting"/"serving" phases of the single
// in-flight interrupt; after every clock edge all DUT outputs are compared
// against it. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req = '0;
   logic        ack = 1'b0;
   logic        eoi = 1'b0;
   logic        mask_w = 1'b0;
   logic [15:0] mask_d = '0;
   logic        irq;
   logic [3:0]  ic;
   logic [15:0] pending;
   logic [15:0] mask;
   logic        busy;

   int nAssert = 0;
   int nFail   = 0;
   int irqCount;

   // Reference model state
   logic [15:0] mPrev;
   logic [15:0] mPend;
   logic [15:0] mMask;
   logic [3:0]  mIc;
   bit          mPresenting;
   bit          mServing;

   interrupt_controller #(
      .RESET_MASK (16'hFFFF),
      .NUM_SRC    (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .ack     (ack),
      .eoi     (eoi),
      .mask_w  (mask_w),
      .mask_d  (mask_d),
      .irq     (irq),
      .ic      (ic),
      .pending (pending),
      .mask    (mask),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Lowest set bit via isolate-lowest-one then log2.
   function automatic logic [3:0] lowestSet(input logic [15:0] v);
      logic [15:0] iso;
      iso = v & (~v + 16'd1);
      return 4'($clog2(iso));
   endfunction

   task automatic modelReset();
      mPrev       = '0;
      mPend       = '0;
      mMask       = 16'hFFFF;
      mIc         = 4'd0;
      mPresenting = 1'b0;
      mServing    = 1'b0;
   endtask

   // One clock edge of the reference behaviour, using the inputs in force.
   task automatic modelEdge();
      logic [15:0] rise;
      logic [15:0] elig;
      logic [15:0] clear;
      rise  = req & ~mPrev;
      elig  = mPend & ~mMask;
      clear = '0;
      if (mPresenting) begin
         if (ack) begin
            clear[mIc]  = 1'b1;
            mPresenting = 1'b0;
            mServing    = 1'b1;
         end
      end else if (mServing) begin
         if (eoi) mServing = 1'b0;
      end else if (elig != 0) begin
         mIc         = lowestSet(elig);
         mPresenting = 1'b1;
      end
      mPend = (mPend & ~clear) | rise;
      if (mask_w) mMask = mask_d;
      mPrev = req;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      check("irq",     32'(irq),     32'(mPresenting));
      check("ic",      32'(ic),      32'(mIc));
      check("pending", 32'(pending), 32'(mPend));
      check("mask",    32'(mask),    32'(mMask));
      check("busy",    32'(busy),    32'(mPresenting | mServing));
   endtask

   // Drive one cycle of inputs (from a negedge), step the model at the
   // posedge and compare at the following negedge. Strobes are one-cycle.
   task automatic applyStimulus(input logic [15:0] r, input logic a, input logic e,
                                input logic mw, input logic [15:0] md);
      req    = r;
      ack    = a;
      eoi    = e;
      mask_w = mw;
      mask_d = md;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      ack    = 1'b0;
      eoi    = 1'b0;
      mask_w = 1'b0;
      checkOutput();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear at once.
   task automatic doReset();
      #2;
      req = '0;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] r;
      logic a;
      logic e;
      logic mw;
      logic [15:0] md;

      modelReset();
      @(negedge clk);
      checkOutput();
      rst = 1'b0;

      // Move away from reset values, then reset mid-cycle
      applyStimulus(16'h0000, 0, 0, 1, 16'h0000);
      applyStimulus(16'h0080, 0, 0, 0, 16'h0000);
      doReset();
      check("reset_mask", 32'(mask), 32'h0000_FFFF);

      // Masked source is latched but not presented
      applyStimulus(16'h0008, 0, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      check("masked_pending", 32'(pending), 32'h0000_0008);
      check("masked_noirq", 32'(irq), 32'h0);

      // Unmask: source 3 is presented and served first
      applyStimulus(16'h0000, 0, 0, 1, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      check("unmask_ic3", 32'(ic), 32'h3);
      applyStimulus(16'h0000, 1, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 1, 0, 16'h0000);

      // Basic handshake on source 5
      applyStimulus(16'h0020, 0, 0, 0, 16'h0000);
      check("hs_pending5", 32'(pending), 32'h0000_0020);
      check("hs_irq_latency", 32'(irq), 32'h0);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      check("hs_irq", 32'(irq), 32'h1);
      check("hs_ic5", 32'(ic), 32'h5);
      applyStimulus(16'h0000, 1, 0, 0, 16'h0000);
      check("hs_ack_pending", 32'(pending), 32'h0);
      check("hs_ack_busy", 32'(busy), 32'h1);
      applyStimulus(16'h0000, 0, 1, 0, 16'h0000);
      check("hs_eoi_busy", 32'(busy), 32'h0);

      // Priority, no preemption
      applyStimulus(16'h0204, 0, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      check("prio_ic2", 32'(ic), 32'h2);
      applyStimulus(16'h0001, 0, 0, 0, 16'h0000);
      check("noprempt_ic2", 32'(ic), 32'h2);
      applyStimulus(16'h0000, 1, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 1, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      check("prio_ic0", 32'(ic), 32'h0);
      applyStimulus(16'h0000, 1, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 1, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      check("prio_ic9", 32'(ic), 32'h9);
      applyStimulus(16'h0000, 1, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 1, 0, 16'h0000);

      // Mask interplay on source 4
      applyStimulus(16'h0000, 0, 0, 1, 16'h0010);
      applyStimulus(16'h0010, 0, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      check("mask4_noirq", 32'(irq), 32'h0);
      applyStimulus(16'h0000, 0, 0, 1, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      check("mask4_irq", 32'(irq), 32'h1);
      check("mask4_ic", 32'(ic), 32'h4);
      applyStimulus(16'h0000, 1, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 1, 0, 16'h0000);

      // Set beats clear on source 6
      applyStimulus(16'h0040, 0, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      applyStimulus(16'h0040, 1, 0, 0, 16'h0000);
      check("setwins_pending6", 32'(pending[6]), 32'h1);
      applyStimulus(16'h0000, 0, 1, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      check("setwins_reirq_ic6", 32'(ic), 32'h6);
      applyStimulus(16'h0000, 1, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 1, 0, 16'h0000);

      // Held level raises exactly one interrupt
      irqCount = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(16'h0002, mPresenting, mServing, 0, 16'h0000);
         if (irq === 1'b1) irqCount++;
      end
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      check("held_one_irq", 32'(irqCount), 32'h1);

      // Stray strobes and ACK+EOI together
      applyStimulus(16'h0000, 1, 0, 0, 16'h0000);
      check("stray_ack_idle", 32'(busy), 32'h0);
      applyStimulus(16'h0001, 0, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 0, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 1, 0, 16'h0000);
      check("stray_eoi_assert", 32'(irq), 32'h1);
      applyStimulus(16'h0000, 1, 1, 0, 16'h0000);
      check("ack_eoi_service", 32'(busy), 32'h1);

      // Reset while in service
      doReset();
      check("rst_service_busy", 32'(busy), 32'h0);

      // Randomized run against the model
      applyStimulus(16'h0000, 0, 0, 1, 16'h0000);
      for (int i = 0; i < 600; i++) begin
         r  = 16'($urandom) & 16'($urandom) & 16'($urandom);
         a  = mPresenting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         e  = mServing    ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         mw = ($urandom_range(0, 19) == 0);
         md = 16'($urandom) & 16'($urandom);
         applyStimulus(r, a, e, mw, md);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
